pipeline_run_controller: RTL and testbench
==========================================

Name: pipeline_run_controller

Overview:
- Synthesizable run controller that sequences reset release and run duration for one or more pipelined cores (NUM_CORES).
- Holds every core in reset, then releases the cores one at a time with a programmable stagger.
- Counts run cycles and stops the cores on halt or, optionally, at a fixed cycle limit.
- Sits between the board or bench reset and each core's active-high `reset` input.

Parameters:
- NUM_CORES, 1, number of core reset channels (>=1)
- HOLD_CYCLES, 2, cycles all cores stay in reset after start (>=1)
- STAGGER_CYCLES, 1, cycles between successive core releases (>=1)
- RUN_CYCLES, 50, run-cycle limit, used only with RUN_LIMIT_EN
- CNT_W, 32, width of the run-cycle counter

Ports:
- clk  in  1  single clock, rising edge
- reset  in  1  asynchronous, active-low; resets the whole block
- start  in  1  1-cycle start request
- halt  in  1  stop request, level-sampled
- core_reset  out  NUM_CORES  per-core active-high reset; bit i drives core i
- running  out  1  high while in RUN
- done  out  1  sticky run-complete flag
- cycle_count  out  CNT_W  cycles spent in RUN
- state  out  3  encoded FSM state: IDLE=0, HOLD=1, STAGGER=2, RUN=3, DONE=4

Behaviour:
- Reset (reset=0) acts immediately, with no clock required. Reset values:
  - state=IDLE, core_reset=all ones, running=0, done=0, cycle_count=0
  - internal hold and stagger counters=0
- Reset asserted mid-operation returns to these values at once. Release is synchronous: the first state change is on the first rising edge with reset=1.
- All outputs are registered; none is combinational from start or halt.
- IDLE:
  - core_reset all ones.
  - start=1 -> HOLD, hold_cnt=0.
- HOLD:
  - hold_cnt increments each edge.
  - On the edge where hold_cnt==HOLD_CYCLES-1, core_reset[0] goes to 0 on that same edge.
  - If NUM_CORES==1, next state is RUN; otherwise STAGGER with stg_cnt=0.
- STAGGER:
  - stg_cnt increments each edge.
  - Core i (i>=1) is released on the edge where stg_cnt+1 == i*STAGGER_CYCLES.
  - The edge that releases core NUM_CORES-1 also moves to RUN.
  - Released cores stay released until DONE or reset.
- RUN:
  - running=1.
  - cycle_count increments by 1 on every edge spent in RUN and saturates at 2^CNT_W-1 (no wrap).
- halt priority and start handling:
  - halt=1 in HOLD, STAGGER or RUN -> DONE on that edge. halt has priority over every other transition, including the limit.
  - start is ignored in HOLD, STAGGER and RUN.
- DONE:
  - done=1, running=0, core_reset re-asserted to all ones (cores frozen), cycle_count held.
  - start=1 -> HOLD, clearing done, cycle_count and all counters on that edge.
  - halt in DONE or IDLE has no effect.
- Simultaneous start and halt in DONE: start wins; halt is re-evaluated from the next cycle.
- State encodings 5-7 are unreachable; if entered, the next edge goes to IDLE.

Optional Feature:
- Macro: RUN_LIMIT_EN.
- Defined: in RUN, the edge on which cycle_count becomes RUN_CYCLES also moves to DONE, so the final cycle_count equals RUN_CYCLES exactly. halt still ends the run early.
- Undefined: no limit logic; RUN ends only on halt or reset, and RUN_CYCLES is unused.

Test Plan:
- NUM_CORES=2, HOLD=2, STAGGER=3; start sampled at edge E0:
  - state=HOLD after E0.
  - core_reset=2'b10 after E2.
  - core_reset=2'b00, state=RUN, running=1 after E5.
  - cycle_count=1 after E6.
- RUN_LIMIT_EN, RUN_CYCLES=50, same config: done=1, running=0, core_reset=2'b11, cycle_count=50 after E55. Outputs stay stable for 20 more cycles.
- halt=1 sampled at E3 (STAGGER): state=DONE after E3, core_reset returns to 2'b11, core 1 is never released, cycle_count=0.
- reset driven low between edges while in RUN with cycle_count=17: all outputs reach reset values before the next edge. After release, the block sits in IDLE until start.
- In DONE, assert start and halt together: state=HOLD, done=0, cycle_count=0 on that edge. The restart timeline then matches the first scenario.
- Macro undefined, CNT_W=4, NUM_CORES=1, HOLD=1:
  - Run 40 cycles: cycle_count saturates at 15, running stays 1, done stays 0.
  - Then halt -> DONE, cycle_count=15.

Source files
------------

// File: rtl/pipeline_run_controller.sv
// Run controller: holds NUM_CORES cores in reset, releases them one at a time, then counts run cycles.
// Define RUN_LIMIT_EN to end the run automatically once cycle_count reaches RUN_CYCLES.
module pipeline_run_controller #(
  parameter int NUM_CORES      = 1,
  parameter int HOLD_CYCLES    = 2,
  parameter int STAGGER_CYCLES = 1,
  parameter int RUN_CYCLES     = 50,
  parameter int CNT_W          = 32
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 start,
  input  logic                 halt,
  output logic [NUM_CORES-1:0] core_reset,
  output logic                 running,
  output logic                 done,
  output logic [CNT_W-1:0]     cycle_count,
  output logic [2:0]           state
);

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_HOLD    = 3'd1,
    ST_STAGGER = 3'd2,
    ST_RUN     = 3'd3,
    ST_DONE    = 3'd4
  } state_e;

  localparam int HOLD_W   = $clog2(HOLD_CYCLES + 1);
  localparam int STG_SPAN = (NUM_CORES - 1) * STAGGER_CYCLES;
  localparam int STG_W    = (STG_SPAN > 0) ? $clog2(STG_SPAN + 1) : 1;
`ifdef RUN_LIMIT_EN
  localparam int LIM_W    = (CNT_W > 32) ? CNT_W : 32;
`endif

  state_e                 state_q, state_d;
  logic [HOLD_W-1:0]      hold_q, hold_d;
  logic [STG_W-1:0]       stg_q, stg_d;
  logic [NUM_CORES-1:0]   core_q, core_d;
  logic [CNT_W-1:0]       cnt_q, cnt_d;
  logic                   running_q, running_d;
  logic                   done_q, done_d;

  always_comb begin
    // NOTE: every signal written here gets a default first so no path can infer a latch.
    state_d = state_q;
    hold_d  = hold_q;
    stg_d   = stg_q;
    core_d  = core_q;
    cnt_d   = cnt_q;

    case (state_q)
      ST_IDLE: begin
        core_d = '1;
        if (start) begin
          state_d = ST_HOLD;
          hold_d  = '0;
          stg_d   = '0;
          cnt_d   = '0;
        end
      end

      ST_HOLD: begin
        if (halt) begin
          state_d = ST_DONE;
          core_d  = '1;
        end else begin
          hold_d = hold_q + HOLD_W'(1);
          if (hold_q == HOLD_W'(HOLD_CYCLES - 1)) begin
            core_d[0] = 1'b0;
            stg_d     = '0;
            state_d   = (NUM_CORES == 1) ? ST_RUN : ST_STAGGER;
          end
        end
      end

      ST_STAGGER: begin
        if (halt) begin
          state_d = ST_DONE;
          core_d  = '1;
        end else begin
          stg_d = stg_q + STG_W'(1);
          // Core i leaves reset i*STAGGER_CYCLES edges after core 0.
          for (int i = 1; i < NUM_CORES; i++) begin
            if (int'(stg_q) + 1 == i * STAGGER_CYCLES) core_d[i] = 1'b0;
          end
          if (int'(stg_q) + 1 == STG_SPAN) state_d = ST_RUN;
        end
      end

      ST_RUN: begin
        cnt_d = (cnt_q == '1) ? cnt_q : cnt_q + CNT_W'(1);
        if (halt) begin
          state_d = ST_DONE;
          core_d  = '1;
        end
`ifdef RUN_LIMIT_EN
        else if (LIM_W'(cnt_d) == LIM_W'(RUN_CYCLES)) begin
          state_d = ST_DONE;
          core_d  = '1;
        end
`endif
      end

      ST_DONE: begin
        core_d = '1;
        if (start) begin
          state_d = ST_HOLD;
          hold_d  = '0;
          stg_d   = '0;
          cnt_d   = '0;
        end
      end

      default: begin
        state_d = ST_IDLE;
        hold_d  = '0;
        stg_d   = '0;
        core_d  = '1;
        cnt_d   = '0;
      end
    endcase

    running_d = (state_d == ST_RUN);
    done_d    = (state_d == ST_DONE);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= ST_IDLE;
      hold_q    <= '0;
      stg_q     <= '0;
      core_q    <= '1;
      cnt_q     <= '0;
      running_q <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      // NOTE: non-blocking updates so every register samples the pre-edge values.
      state_q   <= state_d;
      hold_q    <= hold_d;
      stg_q     <= stg_d;
      core_q    <= core_d;
      cnt_q     <= cnt_d;
      running_q <= running_d;
      done_q    <= done_d;
    end
  end

  assign core_reset  = core_q;
  assign running     = running_q;
  assign done        = done_q;
  assign cycle_count = cnt_q;
  assign state       = state_q;

endmodule

// File: tb/tb_pipeline_run_controller.sv
// Self-checking bench: a timeline model (edges since start) predicts every output of two controller instances.
module tb_pipeline_run_controller;

  localparam int NC_A = 2, HOLD_A = 2, STG_A = 3, CW_A = 32;
  localparam int NC_B = 1, HOLD_B = 1, STG_B = 1, CW_B = 4;
  localparam int RUN_CYCLES = 50;

  logic clk = 1'b0;
  logic rst_n = 1'b1;
  logic start_a = 1'b0, halt_a = 1'b0, start_b = 1'b0, halt_b = 1'b0;

  logic [NC_A-1:0] core_a;
  logic            running_a, done_a;
  logic [CW_A-1:0] count_a;
  logic [2:0]      state_a;
  logic [NC_B-1:0] core_b;
  logic            running_b, done_b;
  logic [CW_B-1:0] count_b;
  logic [2:0]      state_b;

  int checks = 0;
  int failures = 0;

  pipeline_run_controller #(
    .NUM_CORES(NC_A), .HOLD_CYCLES(HOLD_A), .STAGGER_CYCLES(STG_A),
    .RUN_CYCLES(RUN_CYCLES), .CNT_W(CW_A)
  ) u_dut_a (
    .clk(clk), .reset(rst_n), .start(start_a), .halt(halt_a),
    .core_reset(core_a), .running(running_a), .done(done_a),
    .cycle_count(count_a), .state(state_a)
  );

  pipeline_run_controller #(
    .NUM_CORES(NC_B), .HOLD_CYCLES(HOLD_B), .STAGGER_CYCLES(STG_B),
    .RUN_CYCLES(RUN_CYCLES), .CNT_W(CW_B)
  ) u_dut_b (
    .clk(clk), .reset(rst_n), .start(start_b), .halt(halt_b),
    .core_reset(core_b), .running(running_b), .done(done_b),
    .cycle_count(count_b), .state(state_b)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Model: a run is described only by whether it started, whether it finished,
  // and how many edges have passed since the start edge.
  typedef struct packed {
    bit started;
    bit fin;
    int t;
  } mdl_t;

  function automatic longint run_start(input int nc, input int hold, input int stg);
    return longint'(hold + (nc - 1) * stg);
  endfunction

  function automatic longint mdl_count(input mdl_t m, input int nc, input int hold,
                                       input int stg, input int cw);
    longint d;
    longint mx;
    mx = (longint'(1) << cw) - 1;
    d  = longint'(m.t) - run_start(nc, hold, stg);
    if (!m.started || d < 0) return 0;
    return (d > mx) ? mx : d;
  endfunction

  function automatic logic [2:0] mdl_state(input mdl_t m, input int nc, input int hold, input int stg);
    if (!m.started) return 3'd0;
    if (m.fin) return 3'd4;
    if (m.t < hold) return 3'd1;
    if (m.t < run_start(nc, hold, stg)) return 3'd2;
    return 3'd3;
  endfunction

  function automatic logic [63:0] mdl_cores(input mdl_t m, input int nc, input int hold, input int stg);
    logic [63:0] r;
    r = '0;
    for (int i = 0; i < nc; i++)
      r[i] = !m.started || m.fin || (m.t < hold + i * stg);
    return r;
  endfunction

  function automatic mdl_t mdl_next(input mdl_t m, input bit st, input bit hl, input int nc,
                                    input int hold, input int stg, input int cw);
    mdl_t n;
    n = m;
    if (!m.started || m.fin) begin
      if (st) begin
        n.started = 1'b1;
        n.fin     = 1'b0;
        n.t       = 0;
      end
    end else begin
      n.t = m.t + 1;
      if (hl) n.fin = 1'b1;
`ifdef RUN_LIMIT_EN
      else if (mdl_count(n, nc, hold, stg, cw) == longint'(RUN_CYCLES)) n.fin = 1'b1;
`endif
    end
    return n;
  endfunction

  mdl_t m_a, m_b;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_a <= '0;
      m_b <= '0;
    end else begin
      m_a <= mdl_next(m_a, start_a, halt_a, NC_A, HOLD_A, STG_A, CW_A);
      m_b <= mdl_next(m_b, start_b, halt_b, NC_B, HOLD_B, STG_B, CW_B);
    end
  end

  always @(negedge clk) begin
    check("a.state",   64'(state_a),   64'(mdl_state(m_a, NC_A, HOLD_A, STG_A)));
    check("a.core",    64'(core_a),    mdl_cores(m_a, NC_A, HOLD_A, STG_A));
    check("a.running", 64'(running_a), 64'(mdl_state(m_a, NC_A, HOLD_A, STG_A) == 3'd3));
    check("a.done",    64'(done_a),    64'(mdl_state(m_a, NC_A, HOLD_A, STG_A) == 3'd4));
    check("a.count",   64'(count_a),   64'(mdl_count(m_a, NC_A, HOLD_A, STG_A, CW_A)));
    check("b.state",   64'(state_b),   64'(mdl_state(m_b, NC_B, HOLD_B, STG_B)));
    check("b.core",    64'(core_b),    mdl_cores(m_b, NC_B, HOLD_B, STG_B));
    check("b.running", 64'(running_b), 64'(mdl_state(m_b, NC_B, HOLD_B, STG_B) == 3'd3));
    check("b.done",    64'(done_b),    64'(mdl_state(m_b, NC_B, HOLD_B, STG_B) == 3'd4));
    check("b.count",   64'(count_b),   64'(mdl_count(m_b, NC_B, HOLD_B, STG_B, CW_B)));
  end

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic check_reset_vals(input string tag);
    check({tag, ".state"},   64'(state_a),   64'd0);
    check({tag, ".core"},    64'(core_a),    64'b11);
    check({tag, ".running"}, 64'(running_a), 64'd0);
    check({tag, ".done"},    64'(done_a),    64'd0);
    check({tag, ".count"},   64'(count_a),   64'd0);
  endtask

  task automatic first_timeline(input string tag);
    tick(2);
    check({tag, ".E2.core"}, 64'(core_a), 64'b10);
    tick(3);
    check({tag, ".E5.core"},    64'(core_a),    64'b00);
    check({tag, ".E5.state"},   64'(state_a),   64'd3);
    check({tag, ".E5.running"}, 64'(running_a), 64'd1);
    tick(1);
    check({tag, ".E6.count"}, 64'(count_a), 64'd1);
  endtask

  initial begin
    #1 rst_n = 1'b0;
    tick(2);
    check_reset_vals("por");
    rst_n = 1'b1;
    tick(2);
    check("idle.state", 64'(state_a), 64'd0);

    // Scenario 1: start sampled at E0.
    start_a = 1'b1;
    tick(1);
    start_a = 1'b0;
    check("s1.E0.state", 64'(state_a), 64'd1);
    first_timeline("s1");
    tick(16);
    check("s1.E22.count", 64'(count_a), 64'd17);

    // Asynchronous reset between edges while running.
    #2 rst_n = 1'b0;
    #1 check_reset_vals("async");
    tick(1);
    rst_n = 1'b1;
    tick(3);
    check("post_rst.state", 64'(state_a), 64'd0);
    check("post_rst.core",  64'(core_a),  64'b11);

    // Halt during STAGGER at E3: core 1 never released.
    start_a = 1'b1;
    tick(1);
    start_a = 1'b0;
    tick(2);
    halt_a = 1'b1;
    tick(1);
    halt_a = 1'b0;
    check("halt.E3.state", 64'(state_a), 64'd4);
    check("halt.E3.core",  64'(core_a),  64'b11);
    check("halt.E3.count", 64'(count_a), 64'd0);
    check("halt.E3.done",  64'(done_a),  64'd1);
    tick(5);
    check("halt.later.core", 64'(core_a), 64'b11);

    // start and halt together in DONE: start wins.
    start_a = 1'b1;
    halt_a  = 1'b1;
    tick(1);
    start_a = 1'b0;
    halt_a  = 1'b0;
    check("restart.state", 64'(state_a), 64'd1);
    check("restart.done",  64'(done_a),  64'd0);
    check("restart.count", 64'(count_a), 64'd0);
    first_timeline("restart");
`ifdef RUN_LIMIT_EN
    tick(49);
    check("limit.E55.done",    64'(done_a),    64'd1);
    check("limit.E55.running", 64'(running_a), 64'd0);
    check("limit.E55.core",    64'(core_a),    64'b11);
    check("limit.E55.count",   64'(count_a),   64'd50);
    for (int i = 0; i < 20; i++) begin
      tick(1);
      check("limit.hold.count", 64'(count_a), 64'd50);
      check("limit.hold.state", 64'(state_a), 64'd4);
    end
`else
    tick(9);
    check("run.E15.count", 64'(count_a), 64'd10);
    halt_a = 1'b1;
    tick(1);
    halt_a = 1'b0;
    check("run.halt.state", 64'(state_a), 64'd4);
    check("run.halt.count", 64'(count_a), 64'd11);
    tick(3);
    check("run.halt.count_held", 64'(count_a), 64'd11);
`endif

    // Saturation: 4-bit counter, one core, HOLD=1.
    start_b = 1'b1;
    tick(1);
    start_b = 1'b0;
    check("sat.E0.state", 64'(state_b), 64'd1);
    tick(1);
    check("sat.E1.state", 64'(state_b), 64'd3);
    check("sat.E1.core",  64'(core_b),  64'd0);
    tick(40);
    check("sat.count",   64'(count_b),   64'd15);
    check("sat.running", 64'(running_b), 64'd1);
    check("sat.done",    64'(done_b),    64'd0);
    halt_b = 1'b1;
    tick(1);
    halt_b = 1'b0;
    check("sat.halt.state", 64'(state_b), 64'd4);
    check("sat.halt.count", 64'(count_b), 64'd15);
    check("sat.halt.done",  64'(done_b),  64'd1);
    tick(2);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
